// File: rtl/riscv_pkg.sv
// Shared RV64I decode definitions used by the decode/issue stage and its
// immediate generator: major-opcode constants, immediate-format encodings,
// default datapath widths, and small opcode classification helpers.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 6;

  // RV64I major opcodes (instr[6:0])
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] JAL       = 7'b1101111;

  // Immediate formats; FMT_R doubles as "no immediate" (R-type and illegal)
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      LOAD, OP_IMM, OP_IMM_32, JALR: fmt = FMT_I;
      STORE:                         fmt = FMT_S;
      BRANCH:                        fmt = FMT_B;
      LUI, AUIPC:                    fmt = FMT_U;
      JAL:                           fmt = FMT_J;
      default:                       fmt = FMT_R;
    endcase
    return fmt;
  endfunction

  function automatic logic is_legal(input logic [6:0] opcode);
    logic legal;
    case (opcode)
      LOAD, OP_IMM, AUIPC, OP_IMM_32, STORE, OP, LUI, OP_32,
      BRANCH, JALR, JAL: legal = 1'b1;
      default:           legal = 1'b0;
    endcase
    return legal;
  endfunction

  // rs1 is read by everything except the U-type pair and JAL
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !((opcode == LUI) || (opcode == AUIPC) || (opcode == JAL));
  endfunction

  // rs2 is read by R, S and B formats only
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP) || (opcode == OP_32) || (opcode == STORE) || (opcode == BRANCH);
  endfunction

  // Legal opcodes other than stores and branches produce a register result
  function automatic logic writes_rd(input logic [6:0] opcode);
    return is_legal(opcode) && (opcode != STORE) && (opcode != BRANCH);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: selects the I/S/B/U/J immediate of a
// 32-bit RV64I instruction from its opcode and sign-extends it to XLEN.
// R-type and unrecognised opcodes yield zero.
// Ports:
//   i_instr  in   32    instruction word
//   o_imm    out  XLEN  sign-extended immediate
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm
);

  imm_fmt_e w_fmt;

  assign w_fmt = imm_fmt(i_instr[6:0]);

  always_comb begin
    o_imm = '0;
    case (w_fmt)
      FMT_I: o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      FMT_S: o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B: o_imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      FMT_U: o_imm = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'b0};
      FMT_J: o_imm = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage in front of the 64-bit register file. Slices rs1/rs2/rd
// from the fetched instruction, drives the register-file read addresses,
// captures operands, immediate and decode fields into the ID/EX register, and
// holds a per-register busy scoreboard that stalls issue on RAW hazards until
// writeback retires the pending writer.
// Ports:
//   clk, reset                     clock; asynchronous active-high reset
//   if_valid/if_ready              fetch handshake, if_instr/if_pc payload
//   rf_rs1/rf_rs2, rf_data1/2      combinational register-file read port
//   wb_valid/wb_rd                 writeback retiring a write to wb_rd
//   flush                          squash ID/EX contents
//   ex_valid/ex_ready              execute handshake, ex_* payload
//
// Handshakes: a transfer happens on a rising edge where valid && ready. The
// producer holds its payload stable while valid && !ready; ready may depend
// combinationally on valid-side inputs but valid never depends on ready.
module decode_issue_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [31:0]           if_instr,
  input  logic [XLEN-1:0]       if_pc,
  output logic [REG_ADDR_W-1:0] rf_rs1,
  output logic [REG_ADDR_W-1:0] rf_rs2,
  input  logic [XLEN-1:0]       rf_data1,
  input  logic [XLEN-1:0]       rf_data2,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  flush,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_op1,
  output logic [XLEN-1:0]       ex_op2,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [6:0]            ex_opcode,
  output logic [2:0]            ex_funct3,
  output logic                  ex_funct7b5,
  output logic                  ex_reg_write,
  output logic                  ex_illegal
);

  logic [6:0]       w_opcode;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [4:0]       w_rd;
  logic             w_reg_write;
  logic             w_hazard;
  logic             w_accept;
  logic             w_squash_writer;
  logic [XLEN-1:0]  w_imm;
  logic [31:0]      w_busy_nxt;

  logic [31:0]           r_busy;
  logic                  r_ex_valid;
  logic [XLEN-1:0]       r_ex_pc;
  logic [XLEN-1:0]       r_ex_op1;
  logic [XLEN-1:0]       r_ex_op2;
  logic [XLEN-1:0]       r_ex_imm;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic [6:0]            r_ex_opcode;
  logic [2:0]            r_ex_funct3;
  logic                  r_ex_funct7b5;
  logic                  r_ex_reg_write;
  logic                  r_ex_illegal;

  assign w_opcode = if_instr[6:0];
  assign w_rd     = if_instr[11:7];
  assign w_rs1    = if_instr[19:15];
  assign w_rs2    = if_instr[24:20];

  // Read addresses follow the instruction bits unconditionally
  assign rf_rs1 = {{(REG_ADDR_W-5){1'b0}}, w_rs1};
  assign rf_rs2 = {{(REG_ADDR_W-5){1'b0}}, w_rs2};

  // x0 is never a real destination, so it is never tracked as busy
  assign w_reg_write = writes_rd(w_opcode) && (w_rd != 5'd0);

  // Registered busy only: a writeback landing this cycle still stalls, and the
  // instruction issues next cycle once the register file holds the new value.
  assign w_hazard = (uses_rs1(w_opcode) && (w_rs1 != 5'd0) && r_busy[w_rs1]) ||
                    (uses_rs2(w_opcode) && (w_rs2 != 5'd0) && r_busy[w_rs2]);

  assign if_ready = !w_hazard && !flush && (!r_ex_valid || ex_ready);
  assign w_accept = if_valid && if_ready;

  // A writer squashed before execute took it will never write back
  assign w_squash_writer = flush && r_ex_valid && !ex_ready && r_ex_reg_write;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (if_instr),
    .o_imm   (w_imm)
  );

  // Clears first, then the issuing writer's set, so set wins on the same index
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid && (wb_rd != '0)) w_busy_nxt[wb_rd[4:0]] = 1'b0;
    if (w_squash_writer)           w_busy_nxt[r_ex_rd[4:0]] = 1'b0;
    if (w_accept && w_reg_write)   w_busy_nxt[w_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy         <= '0;
      r_ex_valid     <= 1'b0;
      r_ex_pc        <= '0;
      r_ex_op1       <= '0;
      r_ex_op2       <= '0;
      r_ex_imm       <= '0;
      r_ex_rd        <= '0;
      r_ex_opcode    <= '0;
      r_ex_funct3    <= '0;
      r_ex_funct7b5  <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_illegal   <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (flush)         r_ex_valid <= 1'b0;
      else if (w_accept) r_ex_valid <= 1'b1;
      else if (ex_ready) r_ex_valid <= 1'b0;
      // Payload only changes on accept, which implies the slot is free
      if (w_accept) begin
        r_ex_pc        <= if_pc;
        r_ex_op1       <= (w_rs1 == 5'd0) ? '0 : rf_data1;
        r_ex_op2       <= (w_rs2 == 5'd0) ? '0 : rf_data2;
        r_ex_imm       <= w_imm;
        r_ex_rd        <= {{(REG_ADDR_W-5){1'b0}}, w_rd};
        r_ex_opcode    <= w_opcode;
        r_ex_funct3    <= if_instr[14:12];
        r_ex_funct7b5  <= if_instr[30];
        r_ex_reg_write <= w_reg_write;
        r_ex_illegal   <= !is_legal(w_opcode);
      end
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_pc        = r_ex_pc;
  assign ex_op1       = r_ex_op1;
  assign ex_op2       = r_ex_op2;
  assign ex_imm       = r_ex_imm;
  assign ex_rd        = r_ex_rd;
  assign ex_opcode    = r_ex_opcode;
  assign ex_funct3    = r_ex_funct3;
  assign ex_funct7b5  = r_ex_funct7b5;
  assign ex_reg_write = r_ex_reg_write;
  assign ex_illegal   = r_ex_illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench for decode_issue_stage: directed scenarios followed by a
// randomized stream, all compared against a behavioural model of the stage.
module tb_decode_issue_stage;
  import riscv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        if_valid, if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic [5:0]  rf_rs1, rf_rs2;
  logic [63:0] rf_data1, rf_data2;
  logic        wb_valid;
  logic [5:0]  wb_rd;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [63:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [5:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_reg_write, ex_illegal;

  decode_issue_stage dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  // Register file stand-in; x0 holds garbage on purpose
  logic [63:0] rf[64];
  assign rf_data1 = rf[rf_rs1];
  assign rf_data2 = rf[rf_rs2];

  // ---------------- reference model / scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  bit          m_busy[32];
  bit          m_ex_valid;
  logic [31:0] m_ex_instr;
  logic [63:0] m_ex_pc, m_ex_op1, m_ex_op2;
  logic [31:0] exp_q[$];   // issued instructions, oldest first
  logic [5:0]  wb_q[$];    // writers handed to execute, awaiting writeback
  logic        g_rdy;      // if_ready seen in the most recent cycle

  localparam logic [31:0] ADDI_X5  = 32'hFFF00293; // addi x5,x0,-1
  localparam logic [31:0] ADD_X6   = 32'h00528333; // add  x6,x5,x5
  localparam logic [31:0] ADDI_X7  = 32'h00300393; // addi x7,x0,3
  localparam logic [31:0] ADD_X8   = 32'h00738433; // add  x8,x7,x7
  localparam logic [31:0] ADDI_X9  = 32'h00100493; // addi x9,x0,1
  localparam logic [31:0] ADD_X10  = 32'h00048533; // add  x10,x9,x0

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal(input logic [6:0] op);
    return op inside {OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP_32, OP_IMM_32};
  endfunction

  function automatic bit m_writes(input logic [31:0] ins);
    return m_legal(ins[6:0]) && !(ins[6:0] inside {STORE, BRANCH}) && (ins[11:7] != 5'd0);
  endfunction

  function automatic bit m_use1(input logic [6:0] op);
    return !(op inside {LUI, AUIPC, JAL});
  endfunction

  function automatic bit m_use2(input logic [6:0] op);
    return op inside {OP, OP_32, STORE, BRANCH};
  endfunction

  // Immediate from signed arithmetic on the whole word
  function automatic logic [63:0] m_imm(input logic [31:0] ins);
    longint s;
    logic [6:0] op;
    s  = longint'($signed(ins));
    op = ins[6:0];
    if (op inside {OP_IMM, OP_IMM_32, LOAD, JALR}) return s >>> 20;
    if (op == STORE)  return ((s >>> 25) << 5) | longint'(ins[11:7]);
    if (op == BRANCH) return ((s >>> 31) << 12) | (longint'(ins[7]) << 11) |
                             (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
    if (op inside {LUI, AUIPC}) return (s >>> 12) << 12;
    if (op == JAL)    return ((s >>> 31) << 20) | (longint'(ins[19:12]) << 12) |
                             (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
    return 64'd0;
  endfunction

  task automatic check_ex();
    chk("ex_valid", {63'd0, ex_valid}, {63'd0, m_ex_valid});
    if (m_ex_valid) begin
      chk("ex_pc",        ex_pc,  m_ex_pc);
      chk("ex_op1",       ex_op1, m_ex_op1);
      chk("ex_op2",       ex_op2, m_ex_op2);
      chk("ex_imm",       ex_imm, m_imm(m_ex_instr));
      chk("ex_rd",        {58'd0, ex_rd}, {59'd0, m_ex_instr[11:7]});
      chk("ex_opcode",    {57'd0, ex_opcode}, {57'd0, m_ex_instr[6:0]});
      chk("ex_funct3",    {61'd0, ex_funct3}, {61'd0, m_ex_instr[14:12]});
      chk("ex_funct7b5",  {63'd0, ex_funct7b5}, {63'd0, m_ex_instr[30]});
      chk("ex_reg_write", {63'd0, ex_reg_write}, {63'd0, m_writes(m_ex_instr)});
      chk("ex_illegal",   {63'd0, ex_illegal}, {63'd0, !m_legal(m_ex_instr[6:0])});
    end
  endtask

  // ---------------- driver: one clock cycle, starts just after a rising edge ----
  task automatic cycle(input bit v, input logic [31:0] instr, input bit er,
                       input bit fl, input bit wv, input logic [5:0] wr);
    logic [63:0] pc;
    logic [4:0]  s1, s2, d;
    logic [31:0] x;
    bit          hz, rdy, acc;
    pc = {$urandom, $urandom};
    if_valid = v; if_instr = instr; if_pc = pc;
    ex_ready = er; flush = fl; wb_valid = wv; wb_rd = wr;
    #1;
    s1  = instr[19:15];
    s2  = instr[24:20];
    hz  = (m_use1(instr[6:0]) && s1 != 0 && m_busy[s1]) ||
          (m_use2(instr[6:0]) && s2 != 0 && m_busy[s2]);
    rdy = !hz && !fl && (!m_ex_valid || er);
    acc = v && rdy;
    g_rdy = if_ready;
    chk("if_ready", {63'd0, if_ready}, {63'd0, rdy});
    chk("rf_rs1", {58'd0, rf_rs1}, {59'd0, s1});
    chk("rf_rs2", {58'd0, rf_rs2}, {59'd0, s2});
    // Instruction leaving the stage: compare issue order when execute takes it
    if (m_ex_valid && (er || fl)) begin
      x = exp_q.pop_front();
      if (er) chk("issue_order", {45'd0, ex_funct7b5, ex_funct3, ex_rd, ex_opcode},
                  {45'd0, x[30], x[14:12], 1'b0, x[11:7], x[6:0]});
    end
    d = m_ex_instr[11:7];
    if (m_ex_valid && er && m_writes(m_ex_instr)) wb_q.push_back({1'b0, d});
    if (fl && m_ex_valid && !er && m_writes(m_ex_instr)) m_busy[d] = 1'b0;
    if (wv && wr != 6'd0) m_busy[wr[4:0]] = 1'b0;
    if (acc && m_writes(instr)) m_busy[instr[11:7]] = 1'b1;
    if (acc) begin
      exp_q.push_back(instr);
      m_ex_instr = instr;
      m_ex_pc    = pc;
      m_ex_op1   = (s1 == 0) ? 64'd0 : rf[{1'b0, s1}];
      m_ex_op2   = (s2 == 0) ? 64'd0 : rf[{1'b0, s2}];
    end
    m_ex_valid = !fl && (acc || (m_ex_valid && !er));
    @(posedge clk);
    #1;
    check_ex();
  endtask

  // Remove one pending writeback for register r (downstream order is free)
  task automatic wb_take(input logic [5:0] r);
    for (int i = 0; i < wb_q.size(); i++)
      if (wb_q[i] == r) begin
        wb_q.delete(i);
        break;
      end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_ex_valid = 1'b0;
    m_ex_instr = '0;
    exp_q.delete();
    wb_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0]  ops[12];
    logic [31:0] ins;
    logic [63:0] held_pc;
    logic [5:0]  w;
    bit          wv;
    int          k;

    ops = '{OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP_32, OP_IMM_32, 7'b1110011};
    foreach (rf[i]) rf[i] = {$urandom, $urandom};
    rf[0] = rf[0] | 64'h1;
    reset = 1'b1; if_valid = 0; if_instr = '0; if_pc = '0;
    ex_ready = 0; flush = 0; wb_valid = 0; wb_rd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_ex_pc", ex_pc, 64'd0);
    chk("rst_ex_imm", ex_imm, 64'd0);
    chk("rst_ex_op1", ex_op1, 64'd0);
    chk("rst_ex_reg_write", {63'd0, ex_reg_write}, 64'd0);
    chk("rst_if_ready", {63'd0, if_ready}, 64'd1);
    reset = 1'b0;

    // ADDI x5,x0,-1
    cycle(1, ADDI_X5, 1, 0, 0, 6'd0);
    chk("addi_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_op1", ex_op1, 64'd0);
    chk("addi_rd", {58'd0, ex_rd}, 64'd5);

    // ADD x6,x5,x5 stalls until the cycle after x5 is written back
    cycle(1, ADD_X6, 1, 0, 0, 6'd0);
    chk("raw_stall_rdy", {63'd0, g_rdy}, 64'd0);
    wb_take(6'd5);
    cycle(1, ADD_X6, 1, 0, 1, 6'd5);
    chk("raw_wb_cycle_rdy", {63'd0, g_rdy}, 64'd0);
    cycle(1, ADD_X6, 1, 0, 0, 6'd0);
    chk("raw_issue_rdy", {63'd0, g_rdy}, 64'd1);
    chk("raw_issue_rd", {58'd0, ex_rd}, 64'd6);

    // Execute back-pressure: three cycles held, nothing lost
    held_pc = ex_pc;
    repeat (3) begin
      cycle(1, ADDI_X7, 0, 0, 0, 6'd0);
      chk("bp_rdy", {63'd0, g_rdy}, 64'd0);
    end
    chk("bp_pc_held", ex_pc, held_pc);
    cycle(1, ADDI_X7, 1, 0, 0, 6'd0);
    chk("bp_next_rd", {58'd0, ex_rd}, 64'd7);

    // Flush an unconsumed writer to x7; its dependent issues at once
    cycle(0, 32'd0, 0, 1, 0, 6'd0);
    chk("flush_ex_valid", {63'd0, ex_valid}, 64'd0);
    cycle(1, ADD_X8, 1, 0, 0, 6'd0);
    chk("flush_dep_rdy", {63'd0, g_rdy}, 64'd1);

    // Writer to x9 accepted in the same cycle an older x9 write retires
    cycle(1, ADDI_X9, 1, 0, 0, 6'd0);
    cycle(1, ADDI_X9, 1, 0, 0, 6'd0);
    wb_take(6'd9);
    cycle(1, ADDI_X9, 1, 0, 1, 6'd9);
    cycle(1, ADD_X10, 1, 0, 0, 6'd0);
    chk("set_wins_rdy", {63'd0, g_rdy}, 64'd0);
    while (wb_q.size() > 0) cycle(0, 32'd0, 1, 0, 1, wb_q.pop_front());

    // Reset mid-stream while x5 is busy and an instruction sits in ID/EX
    cycle(1, ADDI_X5, 1, 0, 0, 6'd0);
    if_valid = 1; if_instr = ADD_X6; ex_ready = 0; flush = 0; wb_valid = 0;
    reset = 1'b1;
    #1;
    chk("rst_mid_ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_mid_if_ready", {63'd0, if_ready}, 64'd1);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1, ADD_X6, 1, 0, 0, 6'd0);
    chk("rst_mid_issue", {63'd0, ex_valid}, 64'd1);

    // Randomized stream
    for (int n = 0; n < 600; n++) begin
      k   = $urandom_range(0, 11);
      ins = $urandom;
      ins[6:0]   = ops[k];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      wv = 0; w = '0;
      if (wb_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, wb_q.size() - 1);
        w = wb_q[k];
        wb_q.delete(k);
        wv = 1;
      end else if ($urandom_range(0, 15) == 0) begin
        wv = 1;
      end
      cycle($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, wv, w);
    end
    for (int n = 0; n < 64 && wb_q.size() > 0; n++)
      cycle(0, 32'd0, 1, 0, 1, wb_q.pop_front());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
